// File: rtl/md_pkg.sv
// ---------------------------------------------------------------------------
// md_pkg
// Shared definitions for the multiply/divide unit: md_op encodings, the
// controller state enum, divider geometry and small sign helpers.
// ---------------------------------------------------------------------------
package md_pkg;

    localparam int XLEN      = 32;
    localparam int DIV_ITERS = 32;   // one quotient bit per iteration

    typedef enum logic [2:0] {
        MD_MULT  = 3'b000,
        MD_MULTU = 3'b001,
        MD_DIV   = 3'b010,
        MD_DIVU  = 3'b011,
        MD_MTHI  = 3'b100,
        MD_MTLO  = 3'b101
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX
    } state_e;

    // Magnitude of a value that is negative only when it is a signed operand.
    function automatic logic [XLEN-1:0] to_mag(input logic [XLEN-1:0] v,
                                               input logic          is_signed);
        return (is_signed && v[XLEN-1]) ? (~v + 1'b1) : v;
    endfunction

    // Two's-complement negate when neg is set.
    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v,
                                                 input logic            neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/md_divider.sv
// ---------------------------------------------------------------------------
// md_divider
// Unsigned 32/32 restoring divider, one quotient bit per clock.
// A load pulse captures the operands; 32 cycles later done rises and the
// quotient/remainder stay stable until the next load.
//
// Ports
//   clk        in   clock
//   reset      in   synchronous active-high reset
//   load       in   capture dividend/divisor and start iterating
//   dividend   in   32-bit unsigned dividend
//   divisor    in   32-bit unsigned divisor
//   done       out  result valid (held until next load)
//   quotient   out  32-bit quotient
//   remainder  out  32-bit remainder
// ---------------------------------------------------------------------------
module md_divider
    import md_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    localparam int CNT_W = $clog2(DIV_ITERS + 1);
    localparam logic [CNT_W-1:0] ITERS = CNT_W'(DIV_ITERS);

    logic [XLEN-1:0]  rem_q, rem_d;
    logic [XLEN-1:0]  quo_q, quo_d;     // dividend bits shift out, quotient bits shift in
    logic [XLEN-1:0]  dvs_q;
    logic [CNT_W-1:0] cnt_q;            // iterations still to run
    logic             done_q;

    logic [XLEN:0]    shifted;          // 33-bit partial remainder
    logic [XLEN:0]    diff;
    logic             fits;

    // NOTE: every signal written in always_comb gets a value on every path,
    // otherwise synthesis infers a latch.
    always_comb begin
        shifted = {rem_q, quo_q[XLEN-1]};
        diff    = shifted - {1'b0, dvs_q};
        // diff is non-negative (bit 32 clear) exactly when the divisor fits.
        fits    = ~diff[XLEN];
        rem_d   = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
        quo_d   = {quo_q[XLEN-2:0], fits};
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else if (load) begin
            rem_q  <= '0;
            quo_q  <= dividend;
            dvs_q  <= divisor;
            cnt_q  <= ITERS;
            done_q <= 1'b0;
        end else if (cnt_q != '0) begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            cnt_q  <= cnt_q - 1'b1;
            done_q <= (cnt_q == CNT_W'(1));
        end
    end

    assign done      = done_q;
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/md_unit.sv
// ---------------------------------------------------------------------------
// md_unit
// Multi-cycle multiply/divide unit with HI/LO result registers.
// MULT/MULTU: product computed at acceptance, written to {hi,lo} after
// MULT_LAT busy cycles. DIV/DIVU: 32-cycle unsigned divider on magnitudes
// plus one sign-fix cycle (33 busy cycles). MTHI/MTLO write in one cycle
// without raising busy. Division by zero leaves HI/LO untouched.
//
// Ports
//   clk    in   clock
//   reset  in   synchronous active-high reset
//   start  in   issue md_op (ignored while busy)
//   md_op  in   3-bit operation code (see md_pkg::md_op_e)
//   rs     in   operand A / dividend / MTHI-MTLO source
//   rt     in   operand B / divisor
//   busy   out  operation in flight
//   hi     out  HI register (product high / remainder)
//   lo     out  LO register (product low / quotient)
// ---------------------------------------------------------------------------
module md_unit
    import md_pkg::*;
#(
    parameter int MULT_LAT = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      md_op,
    input  logic [XLEN-1:0] rs,
    input  logic [XLEN-1:0] rt,
    output logic            busy,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int CNT_W = $clog2((MULT_LAT > 33) ? MULT_LAT : 33);
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MULT_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_ITERS - 1);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic [XLEN-1:0]    hi_q, lo_q;
    logic [2*XLEN-1:0]  prod_q, prod_d;
    logic               neg_quo_q, neg_rem_q, div_zero_q;

    logic               accept;
    logic               is_signed;
    logic               is_div_op;
    logic [2*XLEN-1:0]  opa_ext, opb_ext;
    logic [XLEN-1:0]    mag_a, mag_b;

    logic               div_done;
    logic [XLEN-1:0]    div_quo, div_rem;
    logic [XLEN-1:0]    quo_fixed, rem_fixed;

    always_comb begin
        accept    = start && (state_q == S_IDLE);
        // MULTU/DIVU have bit 0 set; MULT/DIV are the signed forms.
        is_signed = ~md_op[0];
        is_div_op = (md_op == MD_DIV) || (md_op == MD_DIVU);

        // Sign/zero extension to 64 bits makes one truncated 64x64 product
        // correct for both signed and unsigned operands.
        opa_ext   = {{XLEN{is_signed & rs[XLEN-1]}}, rs};
        opb_ext   = {{XLEN{is_signed & rt[XLEN-1]}}, rt};
        prod_d    = opa_ext * opb_ext;

        mag_a     = to_mag(rs, is_signed);
        mag_b     = to_mag(rt, is_signed);

        quo_fixed = cond_neg(div_quo, neg_quo_q);
        rem_fixed = cond_neg(div_rem, neg_rem_q);
    end

    md_divider u_divider (
        .clk       (clk),
        .reset     (reset),
        .load      (accept && is_div_op),
        .dividend  (mag_a),
        .divisor   (mag_b),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            prod_q     <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        case (md_op)
                            MD_MULT, MD_MULTU: begin
                                prod_q  <= prod_d;
                                cnt_q   <= MUL_LAST;
                                busy_q  <= 1'b1;
                                state_q <= S_MUL;
                            end
                            MD_DIV, MD_DIVU: begin
                                // Quotient is negative when the signs differ;
                                // the remainder follows the dividend.
                                neg_quo_q  <= is_signed && (rs[XLEN-1] ^ rt[XLEN-1]);
                                neg_rem_q  <= is_signed && rs[XLEN-1];
                                div_zero_q <= (rt == '0);
                                cnt_q      <= DIV_LAST;
                                busy_q     <= 1'b1;
                                state_q    <= S_DIV;
                            end
                            MD_MTHI: hi_q <= rs;
                            MD_MTLO: lo_q <= rs;
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    if (cnt_q == '0) begin
                        {hi_q, lo_q} <= prod_q;
                        busy_q       <= 1'b0;
                        state_q      <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_DIV: begin
                    if (cnt_q == '0) begin
                        state_q <= S_FIX;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_FIX: begin
                    if (!div_zero_q && div_done) begin
                        hi_q <= rem_fixed;
                        lo_q <= quo_fixed;
                    end
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// ---------------------------------------------------------------------------
// tb_md_unit
// Self-checking bench for md_unit: directed scenarios plus a randomized run
// compared against an arithmetic reference model of HI/LO and busy length.
// ---------------------------------------------------------------------------
module tb_md_unit;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 33;
    localparam int MAX_WAIT = 100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  md_op = 3'b111;
    logic [31:0] rs = '0;
    logic [31:0] rt = '0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int tests_run    = 0;
    int tests_failed = 0;

    md_unit #(.MULT_LAT(MULT_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .md_op (md_op),
        .rs    (rs),
        .rt    (rt),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    // Reference model: HI/LO effect of one operation and its busy length.
    task automatic ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                             inout logic [31:0] h, inout logic [31:0] l, output int lat);
        longint      sa, sb, q, r;
        logic [63:0] p;
        lat = 0;
        case (op)
            3'd0: begin
                p = 64'(longint'($signed(a)) * longint'($signed(b)));
                h = p[63:32]; l = p[31:0]; lat = MULT_LAT;
            end
            3'd1: begin
                p = {32'd0, a} * {32'd0, b};
                h = p[63:32]; l = p[31:0]; lat = MULT_LAT;
            end
            3'd2: begin
                lat = DIV_LAT;
                if (b != 0) begin
                    sa = longint'($signed(a));
                    sb = longint'($signed(b));
                    q  = sa / sb;
                    r  = sa % sb;
                    l  = q[31:0];
                    h  = r[31:0];
                end
            end
            3'd3: begin
                lat = DIV_LAT;
                if (b != 0) begin
                    l = a / b;
                    h = a % b;
                end
            end
            3'd4: h = a;
            3'd5: l = a;
            default: ;
        endcase
    endtask

    // Issue one op (called right after a negedge) and count busy cycles.
    // Returns at the negedge of the first cycle busy is low again.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat);
        start = 1'b1; md_op = op; rs = a; rt = b;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (busy && lat < MAX_WAIT) begin
            lat++;
            @(negedge clk);
        end
        if (lat >= MAX_WAIT) begin
            tests_run++; tests_failed++;
            $display("FAIL timeout: op=%0d busy still high after %0d cycles", op, lat);
        end
    endtask

    task automatic expect_result(input string name, input int lat, input int exp_lat,
                                 input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        tests_run++;
        if (lat !== exp_lat || hi !== exp_hi || lo !== exp_lo) begin
            tests_failed++;
            $display("FAIL %s: got lat=%0d hi=%h lo=%h, want lat=%0d hi=%h lo=%h",
                     name, lat, hi, lo, exp_lat, exp_hi, exp_lo);
        end
    endtask

    task automatic test_reset;
        int lat;
        tests_run++;
        if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_state: busy=%b hi=%h lo=%h, want 0/0/0", busy, hi, lo);
        end
        run_op(3'd4, 32'h55, 32'h0, lat);
        run_op(3'd5, 32'h66, 32'h0, lat);
        expect_result("preset_hilo", lat, 0, 32'h55, 32'h66);
        // DIVU 100/7 in flight, then two cycles of reset.
        start = 1'b1; md_op = 3'd3; rs = 32'd100; rt = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_mid_div: busy=%b hi=%h lo=%h, want 0/0/0", busy, hi, lo);
        end
        repeat (40) @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_no_late_write: busy=%b hi=%h lo=%h, want 0/0/0", busy, hi, lo);
        end
    endtask

    task automatic test_mult;
        int lat;
        run_op(3'd0, 32'hFFFF_FFFF, 32'h2, lat);
        expect_result("mult_neg1x2", lat, MULT_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op(3'd1, 32'hFFFF_FFFF, 32'h2, lat);
        expect_result("multu_ffffffffx2", lat, MULT_LAT, 32'h0000_0001, 32'hFFFF_FFFE);
        run_op(3'd0, 32'h1234_5678, 32'h0, lat);
        expect_result("mult_by_zero", lat, MULT_LAT, 32'h0, 32'h0);
        run_op(3'd0, 32'h8000_0000, 32'h8000_0000, lat);
        expect_result("mult_minxmin", lat, MULT_LAT, 32'h4000_0000, 32'h0);
    endtask

    task automatic test_div;
        int lat;
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, lat);
        expect_result("div_m7_by_2", lat, DIV_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op(3'd3, 32'd100, 32'd7, lat);
        expect_result("divu_100_by_7", lat, DIV_LAT, 32'd2, 32'd14);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, lat);
        expect_result("div_overflow", lat, DIV_LAT, 32'h0, 32'h8000_0000);
        run_op(3'd2, 32'd7, 32'hFFFF_FFFE, lat);
        expect_result("div_7_by_m2", lat, DIV_LAT, 32'd1, 32'hFFFF_FFFD);
        run_op(3'd4, 32'h11, 32'h0, lat);
        run_op(3'd5, 32'h22, 32'h0, lat);
        run_op(3'd3, 32'd5, 32'd0, lat);
        expect_result("divu_by_zero", lat, DIV_LAT, 32'h11, 32'h22);
    endtask

    task automatic test_ignore_while_busy;
        int lat;
        start = 1'b1; md_op = 3'd3; rs = 32'd1000; rt = 32'd10;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (busy && lat < MAX_WAIT) begin
            lat++;
            if (lat == 3) begin
                start = 1'b1; md_op = 3'd0; rs = 32'd9; rt = 32'd9;
            end else if (lat == 4) begin
                start = 1'b1; md_op = 3'd5; rs = 32'hABCD; rt = 32'd0;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        expect_result("div_ignores_start", lat, DIV_LAT, 32'd0, 32'd100);
        // MTLO during a multiply.
        start = 1'b1; md_op = 3'd1; rs = 32'd6; rt = 32'd7;
        @(negedge clk);
        md_op = 3'd5; rs = 32'hABCD;
        @(negedge clk);
        start = 1'b0;
        lat = 2;
        while (busy && lat < MAX_WAIT) begin
            lat++;
            @(negedge clk);
        end
        expect_result("mtlo_ignored_busy", lat - 1, MULT_LAT, 32'd0, 32'd42);
        // MTLO when idle: visible next cycle, no busy.
        start = 1'b1; md_op = 3'd5; rs = 32'hABCD;
        @(negedge clk);
        start = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || lo !== 32'hABCD || hi !== 32'd0) begin
            tests_failed++;
            $display("FAIL mtlo_idle: busy=%b hi=%h lo=%h, want busy=0 hi=0 lo=0000abcd",
                     busy, hi, lo);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        run_op(3'd3, 32'd50, 32'd5, lat);
        expect_result("b2b_divu", lat, DIV_LAT, 32'd0, 32'd10);
        // First idle cycle: issue immediately.
        run_op(3'd1, 32'd3, 32'd4, lat);
        expect_result("b2b_multu", lat, MULT_LAT, 32'd0, 32'd12);
        run_op(3'd4, 32'hCAFE, 32'd0, lat);
        expect_result("b2b_mthi", lat, 0, 32'hCAFE, 32'd12);
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            4:       return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random;
        logic [31:0] hi_m, lo_m, a, b;
        logic [2:0]  op;
        int          lat, exp_lat;
        run_op(3'd4, 32'd0, 32'd0, lat);
        run_op(3'd5, 32'd0, 32'd0, lat);
        hi_m = '0; lo_m = '0;
        for (int i = 0; i < 1000; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = rand_operand();
            b  = rand_operand();
            ref_model(op, a, b, hi_m, lo_m, exp_lat);
            run_op(op, a, b, lat);
            tests_run++;
            if (lat !== exp_lat || hi !== hi_m || lo !== lo_m) begin
                tests_failed++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h: got lat=%0d hi=%h lo=%h, want lat=%0d hi=%h lo=%h",
                         i, op, a, b, lat, hi, lo, exp_lat, hi_m, lo_m);
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        test_reset();
        test_mult();
        test_div();
        test_ignore_while_busy();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
